// File: rtl/tag_memory_fa_repl_pkg.sv
// Shared definitions for the fully-associative tag memory: victim policy names,
// the log2 helper macro and the 16-bit replacement LFSR.
`ifndef TAG_MEMORY_FA_REPL_PKG_SV
`define TAG_MEMORY_FA_REPL_PKG_SV

`define CLOG2(x) $clog2(x)

package tag_memory_fa_repl_pkg;

   localparam logic [31:0] POLICY_LRU  = "LRU";
   localparam logic [31:0] POLICY_FIFO = "FIFO";
   localparam logic [31:0] POLICY_RAND = "RAND";

   // x^16 + x^14 + x^13 + x^11 + 1, shifted left with feedback into bit 0
   localparam logic [15:0] LFSR_TAPS      = 16'hB400;
   localparam logic [15:0] LFSR_SEED_SAFE = 16'h0001;

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

`endif

// File: rtl/tag_memory_fa_repl_repl_select_fa.sv
// Replacement candidate selection: lowest free entry while not full, otherwise
// the policy's choice (LRU ages, FIFO pointer or LFSR).
module repl_select_fa
   import tag_memory_fa_repl_pkg::*;
#(
   parameter int          CACHE_BLOCK_CAPACITY = 128,
   parameter logic [31:0] POLICY               = POLICY_LRU,
   parameter int          BW_ADD               = `CLOG2(CACHE_BLOCK_CAPACITY)
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [15:0]                     seed,
   input  logic [CACHE_BLOCK_CAPACITY-1:0] valid,
   input  logic [CACHE_BLOCK_CAPACITY-1:0] valid_nxt,
   input  logic                            wr_touch,
   input  logic                            rm_touch,
   input  logic                            hit_touch,
   input  logic [BW_ADD-1:0]               add,
   input  logic [BW_ADD-1:0]               hit_add,
   output logic [BW_ADD-1:0]               victim
);

   localparam int N = CACHE_BLOCK_CAPACITY;

   logic [BW_ADD-1:0] free_idx;
   logic              any_free;
   logic [BW_ADD-1:0] full_victim;

   always_comb begin
      free_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (!valid_nxt[i]) free_idx = BW_ADD'(i);
      end
   end

   assign any_free = ~&valid_nxt;

   if (POLICY == POLICY_FIFO) begin : g_fifo
      logic [BW_ADD-1:0] ptr;
      logic [BW_ADD-1:0] ptr_nxt;
      logic              unused_fifo;

      assign ptr_nxt     = (wr_touch && add == ptr && &valid) ? ptr + 1'b1 : ptr;
      assign full_victim = ptr_nxt;
      assign unused_fifo = ^{seed, rm_touch, hit_touch, hit_add};

      always_ff @(posedge clock) begin
         if (reset) ptr <= '0;
         else       ptr <= ptr_nxt;
      end
   end else if (POLICY == POLICY_RAND) begin : g_rand
      logic [15:0] lfsr;
      logic [15:0] lfsr_nxt;
      logic        unused_rand;

      assign lfsr_nxt    = lfsr_step(lfsr);
      assign full_victim = lfsr_nxt[BW_ADD-1:0];
      assign unused_rand = ^{valid, wr_touch, rm_touch, hit_touch, add, hit_add};

      always_ff @(posedge clock) begin
         // an all-zero seed would lock the LFSR up
         if (reset) lfsr <= (seed == 16'h0000) ? LFSR_SEED_SAFE : seed;
         else       lfsr <= lfsr_nxt;
      end
   end else begin : g_lru
      // ages form a recency ranking: 0 is most recent, all-ones is the victim
      logic [BW_ADD-1:0] age     [N];
      logic [BW_ADD-1:0] age_nxt [N];
      logic              t_en;
      logic [BW_ADD-1:0] t_idx;
      logic [BW_ADD-1:0] t_age;
      logic [BW_ADD-1:0] rm_age;
      logic [BW_ADD-1:0] lru_idx;
      logic              unused_lru;

      assign unused_lru = ^seed;

      // a write touch outranks a removal, which outranks a lookup hit
      assign t_en   = wr_touch | (hit_touch & ~rm_touch);
      assign t_idx  = wr_touch ? add : hit_add;
      assign t_age  = age[t_idx];
      assign rm_age = age[add];

      always_comb begin
         for (int i = 0; i < N; i++) begin
            age_nxt[i] = age[i];
            if (t_en) begin
               if (BW_ADD'(i) == t_idx)             age_nxt[i] = '0;
               else if (valid[i] && age[i] < t_age) age_nxt[i] = age[i] + 1'b1;
            end else if (rm_touch) begin
               if (BW_ADD'(i) == add)               age_nxt[i] = '1;
               else if (age[i] > rm_age)            age_nxt[i] = age[i] - 1'b1;
            end
         end
      end

      always_comb begin
         lru_idx = '0;
         for (int i = N - 1; i >= 0; i--) begin
            if (age_nxt[i] == '1) lru_idx = BW_ADD'(i);
         end
      end

      assign full_victim = lru_idx;

      always_ff @(posedge clock) begin
         for (int i = 0; i < N; i++) begin
            if (reset) age[i] <= BW_ADD'(i);
            else       age[i] <= age_nxt[i];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) victim <= '0;
      else       victim <= any_free ? free_idx : full_victim;
   end

endmodule

// File: rtl/tag_memory_fa_repl.sv
// Fully-associative tag store with single-cycle lookup, tag readback,
// occupancy tracking and a registered replacement candidate.
module tag_memory_fa_repl
   import tag_memory_fa_repl_pkg::*;
#(
   parameter int          CACHE_BLOCK_CAPACITY = 128,
   parameter int          BW_TAG               = 26,
   parameter logic [31:0] POLICY               = POLICY_LRU,
   localparam int         BW_ADD               = `CLOG2(CACHE_BLOCK_CAPACITY)
) (
   input  logic              clock_i,
   input  logic              reset_i,
   input  logic [15:0]       seed_i,
   input  logic              req_i,
   input  logic [BW_TAG-1:0] tag_i,
   input  logic              wren_i,
   input  logic              rmen_i,
   input  logic [BW_ADD-1:0] add_i,
   output logic              valid_o,
   output logic              hit_o,
   output logic [BW_ADD-1:0] add_o,
   output logic [BW_TAG-1:0] tag_o,
   output logic [BW_ADD-1:0] victim_o,
   output logic              full_o,
   output logic [BW_ADD:0]   count_o
);

   localparam int N = CACHE_BLOCK_CAPACITY;

   logic [BW_TAG-1:0] tag_mem [N];
   logic [N-1:0]      valid;
   logic [N-1:0]      valid_nxt;
   logic [N-1:0]      match;
   logic              match_any;
   logic [BW_ADD-1:0] match_idx;
   logic              rm_eff;
   logic [BW_ADD:0]   count_nxt;

   // lookups see the contents as they stood before this cycle's write/remove
   always_comb begin
      for (int i = 0; i < N; i++) begin
         match[i] = valid[i] && (tag_mem[i] == tag_i);
      end
   end

   always_comb begin
      match_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (match[i]) match_idx = BW_ADD'(i);
      end
   end

   assign match_any = |match;
   assign rm_eff    = rmen_i & ~wren_i & valid[add_i];

   always_comb begin
      valid_nxt = valid;
      if (wren_i)      valid_nxt[add_i] = 1'b1;
      else if (rmen_i) valid_nxt[add_i] = 1'b0;
   end

   always_comb begin
      count_nxt = '0;
      for (int i = 0; i < N; i++) begin
         count_nxt = count_nxt + {{BW_ADD{1'b0}}, valid_nxt[i]};
      end
   end

   always_ff @(posedge clock_i) begin
      if (wren_i) tag_mem[add_i] <= tag_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         valid   <= '0;
         valid_o <= 1'b0;
         hit_o   <= 1'b0;
         add_o   <= '0;
         tag_o   <= '0;
         count_o <= '0;
         full_o  <= 1'b0;
      end else begin
         valid   <= valid_nxt;
         valid_o <= req_i;
         hit_o   <= req_i & match_any;
         add_o   <= (req_i & match_any) ? match_idx : '0;
         tag_o   <= wren_i ? tag_i : tag_mem[add_i];
         count_o <= count_nxt;
         full_o  <= &valid_nxt;
      end
   end

   repl_select_fa #(
      .CACHE_BLOCK_CAPACITY (CACHE_BLOCK_CAPACITY),
      .POLICY               (POLICY),
      .BW_ADD               (BW_ADD)
   ) u_repl (
      .clock     (clock_i),
      .reset     (reset_i),
      .seed      (seed_i),
      .valid     (valid),
      .valid_nxt (valid_nxt),
      .wr_touch  (wren_i),
      .rm_touch  (rm_eff),
      .hit_touch (req_i & match_any),
      .add       (add_i),
      .hit_add   (match_idx),
      .victim    (victim_o)
   );

endmodule

// File: tb/tb_tag_memory_fa_repl.sv
// Drives LRU, FIFO and RAND instances with one directed sequence; lookup
// results go through per-instance scoreboards, state outputs are checked inline.
module tb_tag_memory_fa_repl;

   typedef struct packed {
      logic       hit;
      logic [1:0] add;
   } lk_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] seed  = 16'h0000;
   logic        req   = 1'b0;
   logic [7:0]  tag   = 8'h00;
   logic        wren  = 1'b0;
   logic        rmen  = 1'b0;
   logic [1:0]  add   = 2'd0;

   logic [2:0]  vld;
   logic [2:0]  hit;
   logic [2:0]  full;
   logic [1:0]  addo [3];
   logic [7:0]  tago [3];
   logic [1:0]  vic  [3];
   logic [2:0]  cnt  [3];

   int vectors     = 0;
   int miscompares = 0;

   lk_t         sbq [3][$];
   string       pname [3] = '{"lru", "fifo", "rand"};
   logic [15:0] m_lfsr;

   always #5 clock = ~clock;

   tag_memory_fa_repl #(.CACHE_BLOCK_CAPACITY(4), .BW_TAG(8), .POLICY("LRU")) u_lru (
      .clock_i(clock), .reset_i(reset), .seed_i(seed), .req_i(req), .tag_i(tag),
      .wren_i(wren), .rmen_i(rmen), .add_i(add), .valid_o(vld[0]), .hit_o(hit[0]),
      .add_o(addo[0]), .tag_o(tago[0]), .victim_o(vic[0]), .full_o(full[0]), .count_o(cnt[0]));

   tag_memory_fa_repl #(.CACHE_BLOCK_CAPACITY(4), .BW_TAG(8), .POLICY("FIFO")) u_fifo (
      .clock_i(clock), .reset_i(reset), .seed_i(seed), .req_i(req), .tag_i(tag),
      .wren_i(wren), .rmen_i(rmen), .add_i(add), .valid_o(vld[1]), .hit_o(hit[1]),
      .add_o(addo[1]), .tag_o(tago[1]), .victim_o(vic[1]), .full_o(full[1]), .count_o(cnt[1]));

   tag_memory_fa_repl #(.CACHE_BLOCK_CAPACITY(4), .BW_TAG(8), .POLICY("RAND")) u_rand (
      .clock_i(clock), .reset_i(reset), .seed_i(seed), .req_i(req), .tag_i(tag),
      .wren_i(wren), .rmen_i(rmen), .add_i(add), .valid_o(vld[2]), .hit_o(hit[2]),
      .add_o(addo[2]), .tag_o(tago[2]), .victim_o(vic[2]), .full_o(full[2]), .count_o(cnt[2]));

   // reference LFSR: x^16+x^14+x^13+x^11+1, zero seed forced to 1
   always @(posedge clock) begin
      if (reset) m_lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
      else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : g_mon
      lk_t e;
      always @(negedge clock) begin
         if (vld[g]) begin
            if (sbq[g].size() == 0) begin
               chk($sformatf("unexpected_valid_%s", pname[g]), 1, 0);
            end else begin
               e = sbq[g].pop_front();
               chk($sformatf("lookup_%s", pname[g]), int'({hit[g], addo[g]}), int'({e.hit, e.add}));
            end
         end
      end
   end

   // drive one cycle from a negedge; returns at the next negedge
   task automatic step(input logic r, input logic w, input logic m, input logic [7:0] t,
                       input logic [1:0] a, input logic eh, input logic [1:0] ea);
      req = r; wren = w; rmen = m; tag = t; add = a;
      if (r) for (int g = 0; g < 3; g++) sbq[g].push_back('{hit: eh, add: ea});
      @(negedge clock);
      req = 1'b0; wren = 1'b0; rmen = 1'b0;
   endtask

   task automatic chk_occ(input string n, input int c, input int f);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s_count_%s", n, pname[g]), int'(cnt[g]), c);
         chk($sformatf("%s_full_%s", n, pname[g]), int'(full[g]), f);
      end
   endtask

   // er < 0: RAND candidate comes from the reference LFSR
   task automatic chk_vic(input string n, input int el, input int ef, input int er);
      chk($sformatf("%s_victim_lru", n), int'(vic[0]), el);
      chk($sformatf("%s_victim_fifo", n), int'(vic[1]), ef);
      chk($sformatf("%s_victim_rand", n), int'(vic[2]), (er < 0) ? int'(m_lfsr[1:0]) : er);
   endtask

   task automatic chk_tag(input string n, input int t);
      for (int g = 0; g < 3; g++) chk($sformatf("%s_tag_%s", n, pname[g]), int'(tago[g]), t);
   endtask

   int fifo_seq [5] = '{0, 1, 2, 3, 0};
   int lru_after [5] = '{3, 3, 3, 0, 1};
   logic [7:0] fill_tag [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      @(negedge clock);
      @(negedge clock);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_valid_%s", pname[g]), int'(vld[g]), 0);
         chk($sformatf("rst_hit_%s", pname[g]), int'(hit[g]), 0);
         chk($sformatf("rst_add_%s", pname[g]), int'(addo[g]), 0);
      end
      chk_tag("rst", 0);
      chk_occ("rst", 0, 0);
      chk_vic("rst", 0, 0, 0);
      reset = 1'b0;

      // fill entries 0..3
      for (int k = 0; k < 4; k++) begin
         step(0, 1, 0, fill_tag[k], 2'(k), 0, 0);
         chk_tag($sformatf("fill%0d", k), int'(fill_tag[k]));
         chk_occ($sformatf("fill%0d", k), k + 1, (k == 3) ? 1 : 0);
         if (k < 3) chk_vic($sformatf("fill%0d", k), k + 1, k + 1, k + 1);
         else       chk_vic("fill3", 0, 0, -1);
      end

      // idle: RAND candidate walks the LFSR from 0x0001
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 0, 8'h00, 2'd0, 0, 0);
         chk_vic($sformatf("idle%0d", k), 0, 0, -1);
      end

      // LRU hit ordering and basic lookups, back to back
      step(1, 0, 0, 8'h11, 2'd0, 1, 2'd0); chk_vic("hit11", 1, 0, -1);
      step(1, 0, 0, 8'h22, 2'd0, 1, 2'd1); chk_vic("hit22", 2, 0, -1);
      step(1, 0, 0, 8'h33, 2'd0, 1, 2'd2); chk_vic("hit33", 3, 0, -1);
      step(1, 0, 0, 8'h55, 2'd0, 0, 2'd0); chk_vic("miss55", 3, 0, -1);
      step(0, 0, 0, 8'h00, 2'd2, 0, 0);    chk_tag("rd2", 8'h33);

      // write beats remove; same-cycle lookup sees old contents
      step(1, 1, 1, 8'h99, 2'd1, 0, 2'd0);
      chk_occ("wr_rm", 4, 1); chk_tag("wr_rm", 8'h99); chk_vic("wr_rm", 3, 0, -1);
      step(1, 0, 0, 8'h99, 2'd0, 1, 2'd1); chk_vic("hit99", 3, 0, -1);
      step(1, 0, 0, 8'h22, 2'd0, 0, 2'd0);

      // removal, no-op removal, refill
      step(0, 0, 1, 8'h00, 2'd2, 0, 0); chk_occ("rm2", 3, 0); chk_vic("rm2", 2, 2, 2);
      step(0, 0, 1, 8'h00, 2'd2, 0, 0); chk_occ("rm2again", 3, 0); chk_vic("rm2again", 2, 2, 2);
      step(1, 0, 0, 8'h33, 2'd0, 0, 2'd0); chk_vic("miss33", 2, 2, 2);
      step(0, 1, 0, 8'h77, 2'd2, 0, 0); chk_occ("wr77", 4, 1); chk_vic("wr77", 3, 0, -1);

      // FIFO rotation through writes at its candidate
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("fifo_seq%0d", k), int'(vic[1]), fifo_seq[k]);
         step(0, 1, 0, 8'hA0 + 8'(k), 2'(fifo_seq[k]), 0, 0);
         chk($sformatf("fifo_lru%0d", k), int'(vic[0]), lru_after[k]);
         chk_occ($sformatf("fifo_wr%0d", k), 4, 1);
      end
      chk("fifo_wrap", int'(vic[1]), 1);
      step(1, 0, 0, 8'hA4, 2'd0, 1, 2'd0);
      step(1, 0, 0, 8'hA0, 2'd0, 0, 2'd0);
      step(1, 0, 0, 8'hA3, 2'd0, 1, 2'd3); chk_vic("hitA3", 1, 1, -1);

      // one-cycle reset with a lookup in flight
      reset = 1'b1; seed = 16'h00B5; req = 1'b1; tag = 8'hA4;
      @(negedge clock);
      reset = 1'b0; req = 1'b0;
      for (int g = 0; g < 3; g++) chk($sformatf("midrst_valid_%s", pname[g]), int'(vld[g]), 0);
      chk_occ("midrst", 0, 0);
      chk_vic("midrst", 0, 0, 0);

      for (int k = 0; k < 4; k++) step(0, 1, 0, fill_tag[k], 2'(k), 0, 0);
      chk_occ("refill", 4, 1);
      for (int k = 0; k < 24; k++) begin
         step(0, 0, 0, 8'h00, 2'd0, 0, 0);
         chk_vic($sformatf("rand%0d", k), 0, 0, -1);
      end
      step(1, 0, 0, 8'h44, 2'd0, 1, 2'd3);
      step(0, 0, 0, 8'h00, 2'd0, 0, 0);

      for (int g = 0; g < 3; g++) chk($sformatf("drain_%s", pname[g]), sbq[g].size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tag_memory_fa_repl.md
TAG_MEMORY_FA_REPL -- requirements
Module: tag_memory_fa_repl

Interface
REQ-001 The block SHALL have parameter CACHE_BLOCK_CAPACITY, default 128, giving the number of entries (power of two, minimum 2).
REQ-002 The block SHALL have parameter BW_TAG, default 26, giving the tag width.
REQ-003 The block SHALL have parameter POLICY, default "LRU", selecting the victim mode: "LRU", "FIFO" or "RAND".
REQ-004 The block SHALL derive localparam BW_ADD = CLOG2(CACHE_BLOCK_CAPACITY).
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clock_i  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset_i  in  1  synchronous, active-high reset.
REQ-008 seed_i  in  16  LFSR load value, sampled during reset (RAND mode only).
REQ-009 req_i  in  1  lookup request for tag_i.
REQ-010 tag_i  in  BW_TAG  lookup tag, and write tag when wren_i=1.
REQ-011 wren_i  in  1  write tag_i into entry add_i and mark it valid.
REQ-012 rmen_i  in  1  invalidate entry add_i.
REQ-013 add_i  in  BW_ADD  entry index for write, remove and tag readback.
REQ-014 valid_o  out  1  lookup result valid (one-cycle pulse).
REQ-015 hit_o  out  1  lookup hit, qualified by valid_o.
REQ-016 add_o  out  BW_ADD  index of the matching entry.
REQ-017 tag_o  out  BW_TAG  registered tag stored at add_i.
REQ-018 victim_o  out  BW_ADD  current replacement candidate.
REQ-019 full_o  out  1  all entries are valid.
REQ-020 count_o  out  BW_ADD+1  number of valid entries.

Function
REQ-021 A lookup SHALL have 1-cycle latency: req_i at cycle N gives valid_o=1 at N+1 with hit_o/add_o; valid_o=0 otherwise; a new lookup is accepted every cycle.
REQ-022 A lookup SHALL compare against the state before any same-cycle wren_i/rmen_i.
REQ-023 On multiple matches (caller error), add_o SHALL be the lowest matching index; on a miss, add_o=0.
REQ-024 wren_i SHALL take priority over rmen_i in the same cycle; rmen_i on an invalid entry is a no-op.
REQ-025 tag_o SHALL equal the tag stored at add_i one cycle later, reflecting any write in the sampling cycle (write-first).
REQ-026 count_o and full_o SHALL update in the cycle after a valid-bit change; a write to an already-valid entry SHALL NOT change count_o.
REQ-027 If any entry is invalid, victim_o SHALL be the lowest-index invalid entry, in every mode.
REQ-028 LRU mode: each entry SHALL keep a BW_ADD-bit age. A touch (lookup hit or wren_i) of entry k SHALL set age[k]=0 and increment every valid entry whose age < the old age[k]. When full, victim_o SHALL be the entry with age = CACHE_BLOCK_CAPACITY-1.
REQ-029 LRU mode: if a hit touch and a wren_i touch occur in the same cycle, the wren_i touch SHALL be applied and the hit touch discarded; rmen_i SHALL set the removed entry's age to CACHE_BLOCK_CAPACITY-1 and decrement entries older than it.
REQ-030 FIFO mode: a BW_ADD-bit pointer SHALL increment, wrapping modulo capacity, on each wren_i with add_i equal to the pointer while full; when full, victim_o = pointer.
REQ-031 RAND mode: a 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle; when full, victim_o = LFSR[BW_ADD-1:0]; a seed of 0 SHALL be replaced by 16'h0001.
REQ-032 victim_o SHALL be registered and reflect state after the previous edge.

Reset
REQ-033 While reset_i=1: all valid bits, valid_o, hit_o, add_o, tag_o, count_o, full_o and the FIFO pointer SHALL be 0; LRU age[i] SHALL be i; the LFSR SHALL load seed_i.
REQ-034 Reset asserted mid-operation SHALL discard an in-flight lookup: no valid_o in the cycle after reset.
REQ-035 Stored tag contents need not be reset.

Structure
REQ-036 The shared cache package SHALL hold the policy string constants, the CLOG2 macro and the LFSR tap constant.
REQ-037 The victim logic SHALL be a sub-module named repl_select_fa, parameterised by POLICY.

Verification (CACHE_BLOCK_CAPACITY=4, BW_TAG=8 unless stated)
REQ-038 Reset, then write tags 0x11/0x22/0x33/0x44 to entries 0..3 -> victim_o 1,2,3 in turn, then full_o=1, count_o=4.
REQ-039 Lookup 0x33 -> next cycle valid_o=1, hit_o=1, add_o=2. Lookup 0x55 -> hit_o=0, add_o=0.
REQ-040 LRU: fill entries 0..3, hit 0x11 -> victim_o=1; then hit 0x22 -> victim_o=2.
REQ-041 Same cycle wren_i=1 (tag 0x99) and rmen_i=1 with add_i=1 -> entry 1 valid with tag 0x99, count_o unchanged; a same-cycle lookup of 0x99 misses.
REQ-042 FIFO: when full, 5 successive writes at victim_o -> victim_o sequence 0,1,2,3,0.
REQ-043 RAND: seed_i=0, full -> LFSR starts at 0x0001 and victim_o follows the LFSR low 2 bits; reset asserted for one cycle during a lookup -> valid_o=0 after it.
